// File: rtl/msx_bus_initiator.sv
// MSX slot-bus master: single-beat requests become Z80-timed T1/T2/TW/T3 bus cycles.
module msx_bus_initiator #(
  parameter int unsigned MEM_WAITS    = 0,
  parameter int unsigned IO_WAITS     = 1,
  parameter int unsigned WAIT_TIMEOUT = 1024
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        CLK_EN,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WR,
  input  logic        REQ_IO,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic        RSP_ERR,
  output logic [15:0] BUS_ADDR,
  output logic [7:0]  BUS_DOUT,
  output logic        BUS_SLTSL_n,
  output logic        BUS_MERQ_n,
  output logic        BUS_IORQ_n,
  output logic        BUS_RD_n,
  output logic        BUS_WR_n,
  input  logic [7:0]  BUS_DIN,
  input  logic        BUS_BUSDIR_n,
  input  logic        BUS_WAIT_n
);

  localparam int unsigned TMO_W = (WAIT_TIMEOUT == 0) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam logic [3:0]       MEM_W    = 4'(MEM_WAITS);
  localparam logic [3:0]       IO_W     = 4'(IO_WAITS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WAIT_TIMEOUT - 1);
  localparam bit               TMO_EN   = (WAIT_TIMEOUT != 0);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3} state_t;

  state_t           state_q, state_d;
  logic             wr_q, wr_d;
  logic             io_q, io_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       dout_q, dout_d;
  logic             sltsl_q, sltsl_d;
  logic             merq_q, merq_d;
  logic             iorq_q, iorq_d;
  logic             rd_q, rd_d;
  logic             wrn_q, wrn_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             capture, finish, abort;

  assign REQ_READY   = (state_q == S_IDLE);
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_RDATA   = rsp_rdata_q;
  assign RSP_ERR     = rsp_err_q;
  assign BUS_ADDR    = addr_q;
  assign BUS_DOUT    = dout_q;
  assign BUS_SLTSL_n = sltsl_q;
  assign BUS_MERQ_n  = merq_q;
  assign BUS_IORQ_n  = iorq_q;
  assign BUS_RD_n    = rd_q;
  assign BUS_WR_n    = wrn_q;

  // Next-state, strobe and response logic; phases advance only on CLK_EN ticks.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    io_d        = io_q;
    wcnt_d      = wcnt_q;
    tmo_d       = tmo_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    sltsl_d     = sltsl_q;
    merq_d      = merq_q;
    iorq_d      = iorq_q;
    rd_d        = rd_q;
    wrn_d       = wrn_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    capture     = 1'b0;
    finish      = 1'b0;
    abort       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Accept ignores CLK_EN: a coincident tick does not count toward T1.
        if (REQ_VALID) begin
          wr_d    = REQ_WR;
          io_d    = REQ_IO;
          addr_d  = REQ_ADDR;
          dout_d  = REQ_WDATA;
          state_d = S_T1;
        end
      end
      S_T1: begin
        if (CLK_EN) begin
          state_d = S_T2;
          sltsl_d = io_q;
          merq_d  = io_q;
          iorq_d  = ~io_q;
          rd_d    = wr_q;
          wrn_d   = ~wr_q;
          wcnt_d  = io_q ? IO_W : MEM_W;
          tmo_d   = '0;
        end
      end
      S_T2: begin
        // The T2 tick already consumes the first fixed wait state.
        if (CLK_EN) begin
          if (wcnt_q != 4'd0) begin
            wcnt_d  = wcnt_q - 4'd1;
            state_d = S_TW;
          end else if (!BUS_WAIT_n) begin
            state_d = S_TW;
          end else begin
            state_d = S_T3;
            capture = 1'b1;
          end
        end
      end
      S_TW: begin
        if (CLK_EN) begin
          if (wcnt_q != 4'd0) begin
            wcnt_d = wcnt_q - 4'd1;
          end else if (!BUS_WAIT_n) begin
            if (TMO_EN && (tmo_q == TMO_LAST)) begin
              abort  = 1'b1;
              finish = 1'b1;
            end else if (tmo_q != {TMO_W{1'b1}}) begin
              tmo_d = tmo_q + TMO_W'(1);
            end
          end else begin
            state_d = S_T3;
            capture = 1'b1;
          end
        end
      end
      S_T3: begin
        if (CLK_EN) begin
          finish = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Read data sampled on entry to T3; open bus reads as FF.
    if (capture && !wr_q) begin
      rsp_rdata_d = BUS_BUSDIR_n ? 8'hFF : BUS_DIN;
    end

    // Cycle end (normal or aborted): release strobes and pulse the response.
    if (finish) begin
      state_d     = S_IDLE;
      sltsl_d     = 1'b1;
      merq_d      = 1'b1;
      iorq_d      = 1'b1;
      rd_d        = 1'b1;
      wrn_d       = 1'b1;
      rsp_valid_d = 1'b1;
      rsp_err_d   = abort;
      if (abort) begin
        rsp_rdata_d = 8'hFF;
      end
    end
  end

  // State and registered outputs with asynchronous reset.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      io_q        <= 1'b0;
      wcnt_q      <= 4'd0;
      tmo_q       <= '0;
      addr_q      <= 16'h0000;
      dout_q      <= 8'h00;
      sltsl_q     <= 1'b1;
      merq_q      <= 1'b1;
      iorq_q      <= 1'b1;
      rd_q        <= 1'b1;
      wrn_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'hFF;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      io_q        <= io_d;
      wcnt_q      <= wcnt_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      sltsl_q     <= sltsl_d;
      merq_q      <= merq_d;
      iorq_q      <= iorq_d;
      rd_q        <= rd_d;
      wrn_q       <= wrn_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule
